// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SRAM macro.
// The arbiter takes the slave modport; requesters and the SRAM model take master.
interface sram_port_arbiter_if #(
    parameter int DW  = 32,
    parameter int AW  = 12,
    parameter int SAW = 10
);
    logic              m0_req;
    logic              m0_we;
    logic [AW-1:0]     m0_addr;
    logic [DW-1:0]     m0_wdata;
    logic [DW/8-1:0]   m0_be;
    logic              m0_ack;
    logic              m0_err;
    logic [DW-1:0]     m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [AW-1:0]     m1_addr;
    logic [DW-1:0]     m1_wdata;
    logic [DW/8-1:0]   m1_be;
    logic              m1_ack;
    logic              m1_err;
    logic [DW-1:0]     m1_rdata;

    logic              sram_en;
    logic [DW/8-1:0]   sram_we;
    logic [SAW-1:0]    sram_addr;
    logic [DW-1:0]     sram_wdata;
    logic [DW-1:0]     sram_rdata;

    logic              busy;
    logic              last_grant;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        output m1_ack, m1_err, m1_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata,
        output busy, last_grant
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        input  m1_ack, m1_err, m1_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata,
        input  busy, last_grant
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between two requesters.
// Each access runs IDLE -> CMD -> (WAIT) -> RESP; out-of-range goes straight to RESP.
module sram_port_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 12,
    parameter int DEPTH = 1024,
    parameter int SAW   = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    sram_port_arbiter_if.slave    bus
);
    localparam int BW = DW / 8;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [BW-1:0]       be_q, be_d;
    logic                err_q, err_d;
    logic [1:0]          ack_q, ack_d;
    logic [1:0]          rerr_q, rerr_d;
    logic [1:0][DW-1:0]  rdata_q, rdata_d;
    logic                sram_en_q, sram_en_d;
    logic [BW-1:0]       sram_we_q, sram_we_d;
    logic [SAW-1:0]      sram_addr_q, sram_addr_d;
    logic [DW-1:0]       sram_wdata_q, sram_wdata_d;
    logic                busy_q, busy_d;

    logic [1:0]          req;
    logic                sel;

    assign req = {bus.m1_req, bus.m0_req};

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        ack_d        = '0;
        rerr_d       = '0;
        // On a tie the requester that did not win last time goes first.
        sel          = (req == 2'b11) ? ~last_grant_q : req[1];

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d        = sel;
                    last_grant_d = sel;
                    we_d         = sel ? bus.m1_we    : bus.m0_we;
                    addr_d       = sel ? bus.m1_addr  : bus.m0_addr;
                    wdata_d      = sel ? bus.m1_wdata : bus.m0_wdata;
                    be_d         = sel ? bus.m1_be    : bus.m0_be;
                    err_d        = ({1'b0, addr_d} >= DEPTH_W);
                    state_d      = err_d ? RESP : CMD;
                end
            end
            CMD:  state_d = we_q ? RESP : WAIT;
            WAIT: begin
                rdata_d[gnt_q] = bus.sram_rdata;
                state_d        = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered against the state being entered.
        sram_en_d    = (state_d == CMD);
        sram_we_d    = (sram_en_d && we_d) ? be_d : '0;
        sram_addr_d  = sram_en_d ? addr_d[SAW-1:0] : '0;
        sram_wdata_d = (sram_en_d && we_d) ? wdata_d : '0;
        busy_d       = (state_d != IDLE);
        ack_d[gnt_d]  = (state_d == RESP);
        rerr_d[gnt_d] = (state_d == RESP) && err_d;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            err_q        <= 1'b0;
            ack_q        <= '0;
            rerr_q       <= '0;
            rdata_q      <= '0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            err_q        <= err_d;
            ack_q        <= ack_d;
            rerr_q       <= rerr_d;
            rdata_q      <= rdata_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.m0_ack     = ack_q[0];
    assign bus.m0_err     = rerr_q[0];
    assign bus.m0_rdata   = rdata_q[0];
    assign bus.m1_ack     = ack_q[1];
    assign bus.m1_err     = rerr_q[1];
    assign bus.m1_rdata   = rdata_q[1];
    assign bus.sram_en    = sram_en_q;
    assign bus.sram_we    = sram_we_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign bus.busy       = busy_q;
    assign bus.last_grant = last_grant_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: SRAM macro model, transaction-level
// reference model checked every cycle, plus literal expectations per transaction.
module tb_sram_port_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 1024;
    localparam int SAW   = 10;
    localparam int BW    = DW / 8;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    sram_port_arbiter_if #(.DW(DW), .AW(AW), .SAW(SAW)) bus ();

    sram_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .SAW(SAW)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // SRAM macro: read data valid the cycle after a read enable.
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge ACLK) begin
        if (bus.sram_en) begin
            if (bus.sram_we == '0) bus.sram_rdata <= sram_mem[bus.sram_addr];
            for (int b = 0; b < BW; b++)
                if (bus.sram_we[b]) sram_mem[bus.sram_addr][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
        end
    end

    // Reference model: one access at a time, fixed latency per kind, own memory image.
    logic [DW-1:0] mdl_mem [DEPTH];
    bit            m_active, m_who, m_we, m_err, m_last, m_r0, m_r1;
    int            m_k, m_lat;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_res;
    logic [BW-1:0] m_be;
    logic [DW-1:0] m_rdata [2];

    always @(posedge ACLK) begin
        if (ARESET) begin
            m_active = 1'b0; m_last = 1'b1;
            m_rdata[0] = '0; m_rdata[1] = '0;
        end else if (!m_active) begin
            m_r0 = bus.m0_req; m_r1 = bus.m1_req;
            if (m_r0 || m_r1) begin
                m_who   = (m_r0 && m_r1) ? !m_last : m_r1;
                m_last  = m_who;
                m_we    = m_who ? bus.m1_we    : bus.m0_we;
                m_addr  = m_who ? bus.m1_addr  : bus.m0_addr;
                m_wdata = m_who ? bus.m1_wdata : bus.m0_wdata;
                m_be    = m_who ? bus.m1_be    : bus.m0_be;
                m_err   = (int'(m_addr) >= DEPTH);
                m_lat   = m_err ? 1 : (m_we ? 2 : 3);
                if (!m_err && m_we)
                    for (int b = 0; b < BW; b++)
                        if (m_be[b]) mdl_mem[m_addr[SAW-1:0]][b*8 +: 8] = m_wdata[b*8 +: 8];
                m_res    = m_err ? '0 : mdl_mem[m_addr[SAW-1:0]];
                m_active = 1'b1;
                m_k      = 1;
            end
        end else if (m_k == m_lat) begin
            m_active = 1'b0;
        end else begin
            m_k++;
        end
        if (m_active && m_k == m_lat && !m_err && !m_we) m_rdata[m_who] = m_res;
    end

    bit e_en, e_ack0, e_ack1;
    always @(negedge ACLK) begin
        if (chk_en) begin
            e_en   = m_active && m_k == 1 && !m_err;
            e_ack0 = m_active && m_k == m_lat && !m_who;
            e_ack1 = m_active && m_k == m_lat && m_who;
            check("busy",       32'(bus.busy),       32'(m_active));
            check("last_grant", 32'(bus.last_grant), 32'(m_last));
            check("m0_ack",     32'(bus.m0_ack),     32'(e_ack0));
            check("m1_ack",     32'(bus.m1_ack),     32'(e_ack1));
            check("m0_err",     32'(bus.m0_err),     32'(e_ack0 && m_err));
            check("m1_err",     32'(bus.m1_err),     32'(e_ack1 && m_err));
            check("m0_rdata",   bus.m0_rdata,        m_rdata[0]);
            check("m1_rdata",   bus.m1_rdata,        m_rdata[1]);
            check("sram_en",    32'(bus.sram_en),    32'(e_en));
            check("sram_we",    32'(bus.sram_we),    (e_en && m_we) ? 32'(m_be) : 32'd0);
            if (e_en) check("sram_addr", 32'(bus.sram_addr), 32'(m_addr[SAW-1:0]));
            if (e_en && m_we) check("sram_wdata", bus.sram_wdata, m_wdata);
        end
    end

    time t_ack [2];

    // Issues one access; called on a negedge, returns on a negedge with the DUT back in IDLE.
    task automatic do_req(input bit who, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                          output logic [DW-1:0] rdata, output bit err, output int lat);
        bit acked = 1'b0;
        if (who) begin
            bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_be = be; bus.m1_req = 1'b1;
        end else begin
            bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_be = be; bus.m0_req = 1'b1;
        end
        lat = 0;
        while (!acked && lat < 20) begin
            @(negedge ACLK);
            lat++;
            acked = who ? bus.m1_ack : bus.m0_ack;
        end
        check("ack_timeout", 32'(acked), 32'd1);
        t_ack[who] = $time;
        rdata = who ? bus.m1_rdata : bus.m0_rdata;
        err   = who ? bus.m1_err   : bus.m0_err;
        if (who) bus.m1_req = 1'b0; else bus.m0_req = 1'b0;
        $display("m%0d %s addr=%h wdata=%h be=%h -> rdata=%h err=%0d lat=%0d",
                 who, we ? "WR" : "RD", addr, wdata, be, rdata, err, lat);
        @(negedge ACLK);
    endtask

    task automatic m1_burst();
        logic [AW-1:0] addrs [5];
        logic [DW-1:0] exps  [5];
        bit acked;
        int n;
        addrs = '{12'h010, 12'h011, 12'h004, 12'h010, 12'h011};
        exps  = '{32'hABCD0001, 32'hDEAD0011, 32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011};
        bus.m1_we = 1'b0; bus.m1_be = '0; bus.m1_wdata = '0;
        bus.m1_addr = addrs[0]; bus.m1_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            acked = 1'b0; n = 0;
            while (!acked && n < 20) begin
                @(negedge ACLK);
                n++;
                acked = bus.m1_ack;
            end
            check("burst_timeout", 32'(acked), 32'd1);
            check("burst_rdata", bus.m1_rdata, exps[i]);
            $display("m1 RD burst[%0d] addr=%h -> rdata=%h lat=%0d", i, addrs[i], bus.m1_rdata, n);
            if (i < 4) bus.m1_addr = addrs[i+1];
        end
        bus.m1_req = 1'b0;
        @(negedge ACLK);
    endtask

    logic [DW-1:0] rd0, rd1;
    bit            er0, er1;
    int            lt0, lt1;

    initial begin
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be = '0;
        for (int i = 0; i < DEPTH; i++) begin sram_mem[i] = '0; mdl_mem[i] = '0; end
        m_active = 0; m_last = 1; m_k = 0; m_lat = 0; m_rdata[0] = '0; m_rdata[1] = '0;

        repeat (3) @(negedge ACLK);
        chk_en = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_last_grant", 32'(bus.last_grant), 32'd1);
        check("rst_sram_en", 32'(bus.sram_en), 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Basic write then read back.
        do_req(0, 1, 12'h004, 32'h0101FFFF, 4'hF, rd0, er0, lt0);
        check("wr_lat", 32'(lt0), 32'd2);
        check("wr_err", 32'(er0), 32'd0);
        do_req(0, 0, 12'h004, '0, 4'h0, rd0, er0, lt0);
        check("rd_lat", 32'(lt0), 32'd3);
        check("rd_data", rd0, 32'h0101FFFF);

        // Simultaneous requests right after reset: m0 wins the first tie.
        ARESET = 1'b1; @(negedge ACLK); ARESET = 1'b0; @(negedge ACLK);
        fork
            do_req(0, 1, 12'h010, 32'hABCD0001, 4'hF, rd0, er0, lt0);
            do_req(1, 1, 12'h011, 32'hDEAD0011, 4'hF, rd1, er1, lt1);
        join
        check("wr_order_m0_first", 32'(t_ack[0] < t_ack[1]), 32'd1);
        fork
            do_req(0, 0, 12'h010, '0, 4'h0, rd0, er0, lt0);
            do_req(1, 0, 12'h011, '0, 4'h0, rd1, er1, lt1);
        join
        check("rd_m0_data", rd0, 32'hABCD0001);
        check("rd_m1_data", rd1, 32'hDEAD0011);

        // m1 streams reads; m0 must get in within one m1 access.
        fork
            m1_burst();
            begin
                repeat (4) @(negedge ACLK);
                do_req(0, 0, 12'h004, '0, 4'h0, rd0, er0, lt0);
                check("nostarve_lat", 32'(lt0 <= 7), 32'd1);
                check("nostarve_data", rd0, 32'h0101FFFF);
            end
        join

        // Address range boundary.
        do_req(1, 0, 12'h400, '0, 4'h0, rd1, er1, lt1);
        check("oor_lat", 32'(lt1), 32'd1);
        check("oor_err", 32'(er1), 32'd1);
        check("oor_rdata_kept", rd1, 32'hDEAD0011);
        do_req(1, 1, 12'h3FF, 32'h12345678, 4'hF, rd1, er1, lt1);
        check("top_wr_err", 32'(er1), 32'd0);
        do_req(1, 0, 12'h3FF, '0, 4'h0, rd1, er1, lt1);
        check("top_rd_lat", 32'(lt1), 32'd3);
        check("top_rd_data", rd1, 32'h12345678);

        // Byte enables, including an all-zero mask.
        do_req(0, 1, 12'h020, 32'hBEEF0011, 4'hF, rd0, er0, lt0);
        do_req(0, 1, 12'h020, 32'h00000000, 4'h3, rd0, er0, lt0);
        do_req(0, 0, 12'h020, '0, 4'h0, rd0, er0, lt0);
        check("partial_data", rd0, 32'hBEEF0000);
        do_req(0, 1, 12'h020, 32'hFFFFFFFF, 4'h0, rd0, er0, lt0);
        check("be0_err", 32'(er0), 32'd0);
        check("be0_lat", 32'(lt0), 32'd2);
        do_req(0, 0, 12'h020, '0, 4'h0, rd0, er0, lt0);
        check("be0_data", rd0, 32'hBEEF0000);

        // Reset while an m0 read sits in WAIT.
        bus.m0_we = 1'b0; bus.m0_addr = 12'h020; bus.m0_be = '0; bus.m0_req = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b1; bus.m0_req = 1'b0;
        @(negedge ACLK);
        check("midrst_ack", 32'(bus.m0_ack), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_last_grant", 32'(bus.last_grant), 32'd1);
        check("midrst_sram_en", 32'(bus.sram_en), 32'd0);
        check("midrst_rdata", bus.m0_rdata, 32'd0);
        $display("reset during WAIT: m0_ack=%0d busy=%0d last_grant=%0d",
                 bus.m0_ack, bus.busy, bus.last_grant);
        ARESET = 1'b0;
        @(negedge ACLK);
        do_req(0, 0, 12'h020, '0, 4'h0, rd0, er0, lt0);
        check("postrst_lat", 32'(lt0), 32'd3);
        check("postrst_data", rd0, 32'hBEEF0000);

        repeat (2) @(negedge ACLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
